mips_cpu_muldiv: RTL and testbench
==================================

# mips_cpu_muldiv

Iterative multiply/divide sequencer that owns the HI/LO special registers of the MIPS core. It accepts one MULT/MULTU/DIV/DIVU request from the control decoder and runs a shift-add multiplier or restoring divider over WIDTH cycles. It then writes the 64-bit result into HI/LO and asserts `busy` throughout, so the core can stall MFHI/MFLO. MTHI/MTLO writes also land here.

## Interface
- `WIDTH`, 32: operand width; HI/LO are WIDTH each.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `op`  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with `start`.
- `a`  in  WIDTH  rs operand: multiplicand or dividend.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `mthi_en`  in  1  write `wdata` to HI.
- `mtlo_en`  in  1  write `wdata` to LO.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `hi`  out  WIDTH  HI register; reset 0.
- `lo`  out  WIDTH  LO register; reset 0.
- `busy`  out  1  state != IDLE; reset 0.
- `done`  out  1  registered one-cycle pulse when HI/LO take a result; reset 0.

## Operation
- States: IDLE, PREP, RUN, FIX.
- IDLE: on `start`, latch `op`, `a`, `b` and go to PREP.
- PREP:
  - Signed ops (MULT, DIV): take magnitudes of `a` and `b`; record `neg_q = a[W-1]^b[W-1]` and `neg_r = a[W-1]`.
  - Unsigned ops: `neg_q = neg_r = 0`.
  - Clear the 2*WIDTH accumulator and the iteration counter, then go to RUN.
- RUN: one iteration per cycle for exactly WIDTH cycles; the counter is $clog2(WIDTH)+1 bits; on the last iteration go to FIX.
  - Multiply: if multiplier LSB=1, upper half += multiplicand (WIDTH+1-bit sum, carry kept); then shift the {carry, acc} right by 1.
  - Divide (restoring): shift {rem, quot} left by 1; if rem >= divisor, rem -= divisor and quot LSB = 1.
- FIX:
  - Multiply: negate the 64-bit product if `neg_q`.
  - Divide: negate the quotient if `neg_q`; negate the remainder if `neg_r`.
  - Write {HI,LO} (product) or HI=remainder, LO=quotient.
  - Pulse `done`, go to IDLE.
- All arithmetic wraps modulo 2^WIDTH:
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero runs the full latency with no special case: HI=a; LO=0xFFFFFFFF if a>=0 or DIVU, else 0x00000001.
- MTHI/MTLO:
  - In IDLE: write on the next edge.
  - While busy: the write takes effect, and the in-flight operation aborts to IDLE with no `done` and no result write.
  - `mthi_en` and `mtlo_en` together write both registers.
  - MT and `start` in the same IDLE cycle: the MT write wins and `start` is dropped.
- `start` while busy is ignored; the control path stalls instead.
- HI/LO hold their previous values until FIX; the accumulators are internal.

## Timing
- Edge E0 samples `start` → PREP.
- E1 → RUN.
- E2..E(WIDTH+1) perform the iterations.
- E(WIDTH+2) writes HI/LO and returns to IDLE.
- Total WIDTH+3 edges (35 for WIDTH=32).
- `busy` is high from after E0 through E(WIDTH+2); `done` is high for the one cycle following E(WIDTH+2).
- A new `start` is accepted in the same cycle `done` is high (back-to-back).
- `reset_n` low at any time: immediate return to IDLE, `hi=lo=0`, `busy=done=0`, accumulators cleared; release is synchronous to `clk` via the usual reset synchroniser outside this block.

## Structure
- `mips_cpu_pkg`: `muldiv_op_t` enum (MULT/MULTU/DIV/DIVU) and `muldiv_state_t` enum.
- The control decoder maps its MULT/MULTU/DIV/DIVU ALU-op codes onto `muldiv_op_t`.
- One combinational sub-module, `mips_cpu_muldiv_step`: a single multiply-or-divide iteration on {acc, operand}, instantiated once in RUN.
- Sign handling and the FSM live in the top module.

## Test plan
- MULT a=0xFFFFFFFE, b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA; `done` 35 edges after `start`; `busy` high 34 cycles.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; then back-to-back DIVU 7/2 → HI=1, LO=3.
- DIV -7/2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD; DIV 0x80000000/0xFFFFFFFF → HI=0, LO=0x80000000.
- DIVU 5/0 → HI=5, LO=0xFFFFFFFF; DIV -5/0 → HI=0xFFFFFFFB, LO=1.
- `start` asserted mid-operation → ignored, original result unchanged; MTHI wdata=0x1234 at RUN cycle 10 → HI=0x1234, LO unchanged, `busy` low next cycle, no `done`.
- `reset_n` low at RUN cycle 10 → `busy`, `done`, `hi`, `lo` all 0 immediately; a subsequent MULTU 3×4 → LO=12, HI=0.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS core: multiply/divide opcodes and sequencer states.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_t;

    function automatic logic is_div_op(input muldiv_op_t o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input muldiv_op_t o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on {upper, lower}.
module mips_cpu_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        // remainder after the left shift needs one extra bit before the compare
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh[WIDTH-1:0] - operand;
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (rem_sh >= {1'b0, operand}) begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// HI/LO owner: iterative multiply/divide sequencer with MTHI/MTLO abort path.
// state | meaning
// IDLE  | waiting for start or MT write
// PREP  | take operand magnitudes, record result signs, clear accumulator
// RUN   | WIDTH iterations of the step unit
// FIX   | apply signs, write HI/LO, pulse done
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi_en,
    input  logic             mtlo_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    muldiv_state_t    state, state_nx;
    muldiv_op_t       op_q;
    logic [WIDTH-1:0] a_q, b_q, mag_a, mag_b;
    logic [2*WIDTH-1:0] acc, acc_next, prod;
    logic [WIDTH-1:0] quot, rem;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, sgn, div_op, mt_any;
    logic             latch_en, prep_en, iter_en, commit_en;

    assign mt_any = mthi_en | mtlo_en;
    assign sgn    = is_signed_op(op_q);
    assign div_op = is_div_op(op_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_PREP;
            ST_PREP: state_nx = ST_RUN;
            ST_RUN:  if (cnt == CW'(WIDTH - 1)) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        // an MT write always wins: drops a new start or aborts the running op
        if (mt_any) state_nx = ST_IDLE;
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        latch_en  = 1'b0;
        prep_en   = 1'b0;
        iter_en   = 1'b0;
        commit_en = 1'b0;
        case (state)
            ST_IDLE: latch_en  = start & ~mt_any;
            ST_PREP: prep_en   = 1'b1;
            ST_RUN:  iter_en   = 1'b1;
            ST_FIX:  commit_en = ~mt_any;
            default: ;
        endcase
    end

    assign mag_a = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
    assign mag_b = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;

    mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (div_op),
        .acc      (acc),
        .operand  (div_op ? b_q : a_q),
        .acc_next (acc_next)
    );

    assign prod = neg_q ? -acc : acc;
    assign quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= commit_en;
            if (latch_en) begin
                op_q <= muldiv_op_t'(op);
                a_q  <= a;
                b_q  <= b;
            end
            if (prep_en) begin
                a_q   <= mag_a;
                b_q   <= mag_b;
                neg_q <= sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_r <= sgn & a_q[WIDTH-1];
                // lower half starts as multiplier or dividend; upper half clear
                acc   <= {{WIDTH{1'b0}}, (div_op ? mag_a : mag_b)};
                cnt   <= '0;
            end
            if (iter_en) begin
                acc <= acc_next;
                cnt <= cnt + CW'(1);
            end
            if (mt_any) begin
                if (mthi_en) hi <= wdata;
                if (mtlo_en) lo <= wdata;
            end else if (commit_en) begin
                if (div_op) begin
                    hi <= rem;
                    lo <= quot;
                end else begin
                    {hi, lo} <= prod;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed cases plus random ops vs a 64-bit arithmetic model.
module tb_mips_cpu_muldiv;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        mthi_en = 1'b0, mtlo_en = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi_en (mthi_en),
        .mtlo_en (mtlo_en),
        .wdata   (wdata),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // {HI, LO} expected from MIPS semantics using plain 64-bit / integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        int          sx, sy;
        logic [31:0] q, r;
        sx = x;
        sy = y;
        case (o)
            2'd0: p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
            2'd1: p = {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 32'd0)
                    p = {x, (x[31] ? 32'd1 : 32'hFFFF_FFFF)};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    p = {32'd0, 32'h8000_0000};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r, q};
                end
            end
            default: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else            p = {x % y, x / y};
            end
        endcase
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int inject_at, input string tag);
        logic [63:0] exp;
        int edges;
        int busy_cycles;
        exp = model(o, x, y);
        edges = 0;
        busy_cycles = 0;
        start = 1'b1; op = o; a = x; b = y;
        do begin
            @(negedge clk);
            edges++;
            start = 1'b0;
            if (edges == inject_at) begin
                start = 1'b1; op = ~o; a = ~x; b = y + 32'd1;
            end
            if (busy) busy_cycles++;
        end while (!done && edges < 100);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_latency"}, 64'(edges), 64'd35);
        chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd34);
        chk({tag, "_hilo"}, {hi, lo}, exp);
    endtask

    initial begin
        logic [31:0] lo_prev, x, y;
        logic [1:0]  o;
        int          done_cnt;

        repeat (3) @(negedge clk);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        do_op(2'd0, 32'hFFFF_FFFE, 32'd3, -1, "mult_neg");
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
        do_op(2'd3, 32'd7, 32'd2, -1, "divu_b2b");
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);

        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, -1, "div_neg7");
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        do_op(2'd3, 32'd5, 32'd0, -1, "divu_by0");
        do_op(2'd2, 32'hFFFF_FFFB, 32'd0, -1, "div_neg_by0");
        do_op(2'd1, 32'h0000_1111, 32'h0000_2222, 10, "start_ignored");

        // MTHI+MTLO together in IDLE
        @(negedge clk);
        mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        mthi_en = 1'b0; mtlo_en = 1'b0;
        chk("mt_both_hi", 64'(hi), 64'hA5A5_5A5A);
        chk("mt_both_lo", 64'(lo), 64'hA5A5_5A5A);

        // MT and start in the same IDLE cycle: start dropped
        start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3; mtlo_en = 1'b1; wdata = 32'd77;
        @(negedge clk);
        start = 1'b0; mtlo_en = 1'b0;
        chk("mt_start_busy", 64'(busy), 64'd0);
        chk("mt_start_lo", 64'(lo), 64'd77);
        chk("mt_start_hi", 64'(hi), 64'hA5A5_5A5A);

        // MTHI in mid-RUN aborts the operation
        lo_prev = lo;
        start = 1'b1; op = 2'd1; a = $urandom | 32'h1; b = $urandom | 32'h1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("abort_busy_before", 64'(busy), 64'd1);
        mthi_en = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        mthi_en = 1'b0;
        chk("abort_hi", 64'(hi), 64'h1234);
        chk("abort_lo", 64'(lo), 64'(lo_prev));
        chk("abort_busy", 64'(busy), 64'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_hi_kept", 64'(hi), 64'h1234);

        // asynchronous reset in mid-RUN
        start = 1'b1; op = 2'd0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_op(2'd1, 32'd3, 32'd4, -1, "post_reset");

        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 4))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) x = 32'h8000_0000;
            do_op(o, x, y, -1, $sformatf("rand%0d_op%0d", i, o));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
